// File: rtl/gol_step_ctrl.sv
// Generation sequencer for an 8x8 Game-of-Life row array, with host write arbitration.
// Define GOL_TORUS_EN for a toroidal grid; otherwise cells beyond the edges read as dead.
module gol_step_ctrl #(
  parameter int GEN_W = 16
) (
  input  logic             ph2,
  input  logic             reset,
  input  logic             start,
  input  logic             host_we,
  input  logic [2:0]       host_addr,
  input  logic [7:0]       host_data,
  output logic             host_ack,
  output logic [7:0]       host_rdata,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic [2:0]       ra,
  input  logic [7:0]       rd,
  output logic [2:0]       wa,
  output logic [7:0]       wd,
  output logic             regwrite
);

  typedef enum logic [2:0] {IDLE, HWR, RD_N, RD_C, RD_S, CALC, COMMIT, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       r_q, r_d;
  logic [2:0]       ra_q, ra_d;
  logic [2:0]       wa_q, wa_d;
  logic [7:0]       wd_q, wd_d;
  logic             regwrite_q, regwrite_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             host_ack_q, host_ack_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [7:0]       nrow_q, nrow_d;
  logic [7:0]       crow_q, crow_d;
  logic [7:0]       srow_q, srow_d;
  logic [7:0]       row_buf_q [8];
  logic [7:0]       row_buf_d [8];

  function automatic logic [7:0] life_row(input logic [7:0] up, input logic [7:0] mid,
                                          input logic [7:0] dn);
    logic [7:0] nxt;
    logic [2:0] lft;
    logic [2:0] rgt;
    logic [3:0] cnt;
    nxt = '0;
    for (int i = 0; i < 8; i++) begin
      lft = {up[(i+7)%8], mid[(i+7)%8], dn[(i+7)%8]};
      rgt = {up[(i+1)%8], mid[(i+1)%8], dn[(i+1)%8]};
`ifndef GOL_TORUS_EN
      if (i == 0) lft = '0;
      if (i == 7) rgt = '0;
`endif
      cnt = 4'(up[i]) + 4'(dn[i]) + 4'(lft[0]) + 4'(lft[1]) + 4'(lft[2])
          + 4'(rgt[0]) + 4'(rgt[1]) + 4'(rgt[2]);
      nxt[i] = (cnt == 4'd3) | (mid[i] & (cnt == 4'd2));
    end
    return nxt;
  endfunction

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    nrow_d    = nrow_q;
    crow_d    = crow_q;
    srow_d    = srow_q;
    row_buf_d = row_buf_q;
    gen_d     = gen_q;
    case (state_q)
      IDLE: begin
        if (host_we) begin
          state_d = HWR;
        end else if (start) begin
          state_d = RD_N;
          r_d     = 3'd0;
        end
      end
      HWR:  state_d = IDLE;
      RD_N: begin
        nrow_d = rd;
`ifndef GOL_TORUS_EN
        if (r_q == 3'd0) nrow_d = '0;
`endif
        state_d = RD_C;
      end
      RD_C: begin
        crow_d  = rd;
        state_d = RD_S;
      end
      RD_S: begin
        srow_d = rd;
`ifndef GOL_TORUS_EN
        if (r_q == 3'd7) srow_d = '0;
`endif
        state_d = CALC;
      end
      CALC: begin
        row_buf_d[r_q] = life_row(nrow_q, crow_q, srow_q);
        r_d            = r_q + 3'd1;
        state_d        = (r_q == 3'd7) ? COMMIT : RD_N;
      end
      COMMIT: begin
        r_d = r_q + 3'd1;
        if (r_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        gen_d   = gen_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are set up for the state being entered.
    ra_d       = ra_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    regwrite_d = 1'b0;
    host_ack_d = 1'b0;
    busy_d     = state_d inside {RD_N, RD_C, RD_S, CALC, COMMIT, DONE};
    done_d     = (state_d == DONE);
    case (state_d)
      IDLE: ra_d = host_addr;
      HWR: begin
        wa_d       = host_addr;
        wd_d       = host_data;
        regwrite_d = 1'b1;
        host_ack_d = 1'b1;
      end
      RD_N: ra_d = r_d - 3'd1;
      RD_C: ra_d = r_d;
      RD_S: ra_d = r_d + 3'd1;
      COMMIT: begin
        wa_d       = r_d;
        wd_d       = row_buf_q[r_d];
        regwrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q    <= IDLE;
      r_q        <= '0;
      ra_q       <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      host_ack_q <= 1'b0;
      gen_q      <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      ra_q       <= ra_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      regwrite_q <= regwrite_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      host_ack_q <= host_ack_d;
      gen_q      <= gen_d;
    end
  end

  always_ff @(posedge ph2) begin
    nrow_q    <= nrow_d;
    crow_q    <= crow_d;
    srow_q    <= srow_d;
    row_buf_q <= row_buf_d;
  end

  assign ra         = ra_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign regwrite   = regwrite_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign host_ack   = host_ack_q;
  assign gen_count  = gen_q;
  assign host_rdata = rd;

endmodule

// File: tb/tb_gol_step_ctrl.sv
// Directed bench for gol_step_ctrl with an 8x8 row-array model and a write scoreboard.
module tb_gol_step_ctrl;

  logic        ph2 = 1'b0;
  logic        reset, start, host_we;
  logic [2:0]  host_addr;
  logic [7:0]  host_data;
  logic        host_ack, busy, done, regwrite;
  logic [7:0]  host_rdata, rd, wd;
  logic [15:0] gen_count;
  logic [2:0]  ra, wa;

  logic [7:0]  mem [8];
  logic [10:0] wq [$];
  logic [63:0] grid;
  logic [15:0] gen_exp;
  int          total = 0;
  int          bad = 0;

  gol_step_ctrl #(.GEN_W(16)) dut (
    .ph2(ph2), .reset(reset), .start(start), .host_we(host_we),
    .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .host_rdata(host_rdata), .busy(busy), .done(done), .gen_count(gen_count),
    .ra(ra), .rd(rd), .wa(wa), .wd(wd), .regwrite(regwrite)
  );

  always #5 ph2 = ~ph2;

  assign rd = mem[ra];
  always @(posedge ph2) if (regwrite === 1'b1) mem[wa] <= wd;

  function automatic logic [63:0] life_ref(input logic [63:0] g);
    logic [63:0] o;
    int cnt, rr, cc;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef GOL_TORUS_EN
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
`endif
              if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                if (g[rr*8+cc]) cnt++;
            end
          end
        end
        o[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
      end
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [10:0] ew;
    @(posedge ph2);
    #1;
    if (regwrite === 1'b1) begin
      chk("wr_expected", (wq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (wq.size() != 0) begin
        ew = wq.pop_front();
        chk("wr_addr", 32'(wa), 32'(ew[10:8]));
        chk("wr_data", 32'(wd), 32'(ew[7:0]));
      end
    end
  endtask

  task automatic push_gen(input logic [63:0] g);
    for (int k = 0; k < 8; k++) wq.push_back({3'(k), g[8*k +: 8]});
  endtask

  task automatic check_grid(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_row%0d", tag, i), 32'(mem[i]), 32'(grid[8*i +: 8]));
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    int n;
    host_addr = a;
    host_data = d;
    host_we   = 1'b1;
    wq.push_back({a, d});
    n = 0;
    do begin
      tick();
      n++;
    end while (host_ack !== 1'b1 && n < 10);
    chk("host_ack_seen", 32'(host_ack), 32'd1);
    host_we = 1'b0;
    grid[8*a +: 8] = d;
    tick();
    chk("host_ack_pulse", 32'(host_ack), 32'd0);
  endtask

  task automatic load_grid(input logic [63:0] g);
    for (int k = 0; k < 8; k++) host_write(3'(k), g[8*k +: 8]);
  endtask

  // Called in the first busy cycle; returns in the DONE cycle (or the abort cycle).
  task automatic wait_done(input int host_at, input logic [2:0] ha, input logic [7:0] hd,
                           input int abort_at, output bit aborted);
    int lat;
    bit seen;
    lat = 1;
    seen = 1'b0;
    aborted = 1'b0;
    while (!seen && lat <= 100) begin
      chk("busy_in_gen", 32'(busy), 32'd1);
      chk("regwrite_phase", 32'(regwrite), (lat >= 33 && lat <= 40) ? 32'd1 : 32'd0);
      chk("host_ack_blocked", 32'(host_ack), 32'd0);
      if (done === 1'b1) begin
        chk("done_latency", 32'(lat), 32'd41);
        seen = 1'b1;
      end else begin
        if (lat == host_at) begin
          host_addr = ha;
          host_data = hd;
          host_we   = 1'b1;
          wq.push_back({ha, hd});
        end
        if (lat == abort_at) begin
          reset = 1'b1;
          aborted = 1'b1;
          return;
        end
        tick();
        lat++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_gen(input logic [63:0] nx);
    tick();
    grid = nx;
    gen_exp++;
    chk("gen_count", 32'(gen_count), 32'(gen_exp));
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic run_gen();
    logic [63:0] nx;
    bit ab;
    nx = life_ref(grid);
    push_gen(nx);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(-1, 3'd0, 8'd0, -1, ab);
    finish_gen(nx);
    check_grid("gen");
  endtask

  initial begin
    logic [63:0] g1, g2, part;
    bit ab;
    reset = 1'b1; start = 1'b0; host_we = 1'b0;
    host_addr = 3'd5; host_data = 8'hFF;
    gen_exp = '0;
    grid = '0;
    tick();
    tick();
    chk("rst_ra", 32'(ra), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", 32'(wd), 32'd0);
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_gen_count", 32'(gen_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ra_follows_host", 32'(ra), 32'd5);

    // Blinker
    load_grid(64'h0000_0000_1C00_0000);
    host_addr = 3'd3;
    tick();
    chk("host_rdata_row3", 32'(host_rdata), 32'h1C);
    run_gen();
    chk("blinker_r2", 32'(mem[2]), 32'h08);
    chk("blinker_r3", 32'(mem[3]), 32'h08);
    chk("blinker_r4", 32'(mem[4]), 32'h08);
    chk("blinker_r5", 32'(mem[5]), 32'h00);
    run_gen();
    chk("blinker_back_r3", 32'(mem[3]), 32'h1C);
    chk("blinker_back_r2", 32'(mem[2]), 32'h00);
    chk("blinker_gen2", 32'(gen_count), 32'd2);

    // Still-life block
    load_grid(64'h0000_0018_1800_0000);
    for (int i = 0; i < 3; i++) begin
      run_gen();
      chk("block_r3", 32'(mem[3]), 32'h18);
      chk("block_r4", 32'(mem[4]), 32'h18);
    end

    // Corner wrap
    load_grid(64'h8100_0000_0000_0080);
    run_gen();
`ifdef GOL_TORUS_EN
    chk("wrap_r0", 32'(mem[0]), 32'h81);
    chk("wrap_r7", 32'(mem[7]), 32'h81);
`else
    chk("wrap_r0", 32'(mem[0]), 32'h00);
    chk("wrap_r7", 32'(mem[7]), 32'h00);
`endif

    // Host write held during a generation
    load_grid(64'h0000_0000_1C00_0000);
    g1 = life_ref(grid);
    push_gen(g1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, 3'd6, 8'h5A, -1, ab);
    finish_gen(g1);
    chk("arb_idle_no_ack", 32'(host_ack), 32'd0);
    tick();
    chk("arb_ack_after_idle", 32'(host_ack), 32'd1);
    host_we = 1'b0;
    grid[8*6 +: 8] = 8'h5A;
    tick();
    check_grid("arb");

    // host_we and start together: host first
    host_addr = 3'd1; host_data = 8'h07; host_we = 1'b1; start = 1'b1;
    wq.push_back({3'd1, 8'h07});
    grid[8*1 +: 8] = 8'h07;
    g1 = life_ref(grid);
    push_gen(g1);
    tick();
    chk("both_ack_first", 32'(host_ack), 32'd1);
    chk("both_not_busy", 32'(busy), 32'd0);
    host_we = 1'b0;
    tick();
    chk("both_idle_gap", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    wait_done(-1, 3'd0, 8'd0, -1, ab);
    finish_gen(g1);
    check_grid("both");

    // Back-to-back with start held
    g1 = life_ref(grid);
    g2 = life_ref(g1);
    push_gen(g1);
    push_gen(g2);
    start = 1'b1;
    tick();
    wait_done(-1, 3'd0, 8'd0, -1, ab);
    finish_gen(g1);
    tick();
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(-1, 3'd0, 8'd0, -1, ab);
    finish_gen(g2);
    check_grid("b2b");

    // Reset during the third commit cycle
    load_grid(64'h0000_0000_0007_0102);
    g1 = life_ref(grid);
    push_gen(g1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(-1, 3'd0, 8'd0, 35, ab);
    chk("abort_taken", 32'(ab), 32'd1);
    tick();
    chk("abort_regwrite", 32'(regwrite), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_gen_count", 32'(gen_count), 32'd0);
    wq.delete();
    part = grid;
    for (int k = 0; k < 3; k++) part[8*k +: 8] = g1[8*k +: 8];
    grid = part;
    gen_exp = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    check_grid("partial");
    run_gen();
    chk("after_abort_gen", 32'(gen_count), 32'd1);
    chk("wq_drained", 32'(wq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gol_step_ctrl.md
Name: gol_step_ctrl

Overview:
Generation sequencer for the 8x8 Game-of-Life state array (8 rows x 8 bits, async read via ra/rd, write via wa/wd/regwrite).
- On request, reads each row with its two neighbour rows, applies the Life rule and buffers the next-generation rows internally.
- Then commits all 8 rows back to the array.
- Also arbitrates array write access between a host loader and the sequencer.

Parameters:
GEN_W, 16, width of generation counter gen_count (wraps modulo 2^GEN_W)

Ports:
ph2  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level request to compute one generation
host_we  input  1  level request for host row write
host_addr  input  3  host row address (write, and read while idle)
host_data  input  8  host row write data
host_ack  output  1  one-cycle pulse: host write performed this cycle
host_rdata  output  8  equals rd (valid while idle)
busy  output  1  high from first read cycle through done cycle
done  output  1  one-cycle pulse at end of generation
gen_count  output  GEN_W  completed-generation counter
ra  output  3  array read address (registered)
rd  input  8  array read data (combinational from ra)
wa  output  3  array write address (registered)
wd  output  8  array write data (registered)
regwrite  output  1  array write enable (registered)

Behaviour:
- Reset clears all outputs and state in the next cycle:
  - ra=0, wa=0, wd=0, regwrite=0, busy=0, done=0, host_ack=0, gen_count=0, state=IDLE.
  - The row buffer is not cleared.
- Reset mid-operation aborts the generation with no further writes. The array is left partially committed; this is acceptable.
- Row buffer: 8x8 registers. Capture regs N, C, S (8 bits each). Row counter r, 3 bits.
- States: IDLE, HWR, RD_N, RD_C, RD_S, CALC, COMMIT, DONE.
- IDLE: ra=host_addr.
  - host_we=1 -> HWR. Host has priority over start when both are high.
  - Else start=1 -> RD_N with r=0.
  - start and host_we are ignored in every other state (they remain pending as levels).
- HWR (1 cycle): wa=host_addr, wd=host_data, regwrite=1, host_ack=1 -> IDLE. Host must drop host_we after ack, or the write repeats.
- RD_N: ra=r-1 mod 8; rd captured into N at the end of the cycle.
- RD_C: ra=r; capture into C.
- RD_S: ra=r+1 mod 8; capture into S.
- CALC, per column c in 0..7:
  - neighbour count n (4-bit, 0..8) = N[c-1], N[c], N[c+1], C[c-1], C[c+1], S[c-1], S[c], S[c+1], column indices mod 8.
  - next[c] = (n==3) | (C[c] & n==2).
  - buf[r] <= next; r <= r+1.
  - r==7 -> COMMIT with r=0; else -> RD_N.
- COMMIT (8 cycles, k=0..7): wa=k, wd=buf[k], regwrite=1. After k=7 -> DONE.
- DONE (1 cycle): done=1, gen_count <= gen_count+1 -> IDLE.
- busy is high in RD_N through DONE inclusive.
- Latency: start sampled high in IDLE at edge E -> done high in cycle E+41 (32 read/calc + 8 commit + 1 done). regwrite is never high in RD_*/CALC.
- All reads of a generation complete before any commit write, so old/new state never mix.
- start held high continuously -> back-to-back generations with exactly one IDLE cycle between DONE and the next RD_N.

Optional Feature:
GOL_TORUS_EN.
- Defined: row and column neighbour indices wrap modulo 8 (toroidal grid), as described above.
- Undefined: out-of-grid neighbours read as dead.
  - N is forced to 0 for r=0; S is forced to 0 for r=7.
  - Column terms c-1 at c=0 and c+1 at c=7 are 0.
  - Read cycles still occur, so latency is unchanged at 41.

Test Plan:
- Blinker: host writes row3=8'b00011100, others 0; start pulse -> done at E+41; rows 2,3,4 = 8'b00001000, others 0; gen_count=1. Second start -> row3=8'b00011100 again; gen_count=2.
- Still-life block: rows 3,4 = 8'b00011000 -> unchanged after 3 generations; regwrite high exactly 8 cycles per generation.
- Wrap: cells (row7,bit7), (row7,bit0), (row0,bit7) set.
  - With GOL_TORUS_EN: (row0,bit0) is born, giving a 2x2 block across the corners; all 4 cells live.
  - Without GOL_TORUS_EN: all rows 0 after one step.
- Arbitration: host_we held from cycle E+5 during a generation -> no host_ack until after DONE; host_ack occurs in the first cycle after the first IDLE. host_we and start high together in IDLE -> HWR first, generation starts afterward.
- Reset mid-op: reset asserted during 3rd COMMIT cycle -> next cycle regwrite=0, busy=0, done never pulses, gen_count=0; a subsequent start runs a full 41-cycle generation.
